// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one SRAM-like bus between fetch and MEM data ports (data first).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_stall,
    input  logic [1:0]          d_en,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [2:0]          d_size,
    input  logic [DATA_W/8-1:0] w_byte_select,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [2:0]          bus_size,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_D_REQ  = 3'd1,
        S_D_WAIT = 3'd2,
        S_I_REQ  = 3'd3,
        S_I_WAIT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                d_done_q, d_done_d;
    logic                i_done_q, i_done_d;
    logic [DATA_W-1:0]   d_buf_q, d_buf_d;
    logic [DATA_W-1:0]   i_buf_q, i_buf_d;

    logic w_d_valid, w_d_pend, w_i_pend;
    logic w_d_fin, w_i_fin;
    logic w_d_stall, w_i_stall, w_advance;
    logic w_sel_d, w_sel_i;

    assign w_d_valid = (d_en == 2'b01) || (d_en == 2'b10);
    assign w_d_pend  = w_d_valid && !d_done_q;
    assign w_i_pend  = i_en && !i_done_q;

    // A port finishes in the cycle its data_ok arrives while we wait on it.
    assign w_d_fin   = (state_q == S_D_WAIT) && bus_data_ok;
    assign w_i_fin   = (state_q == S_I_WAIT) && bus_data_ok;

    assign w_d_stall = w_d_valid && !(d_done_q || w_d_fin);
    assign w_i_stall = i_en && !(i_done_q || w_i_fin);
    assign w_advance = !w_d_stall && !w_i_stall;

    // REQ states keep their grant even if a higher-priority port shows up.
    assign w_sel_d = ((state_q == S_IDLE) && w_d_pend) || (state_q == S_D_REQ);
    assign w_sel_i = ((state_q == S_IDLE) && !w_d_pend && w_i_pend) || (state_q == S_I_REQ);

    always_comb begin
        bus_wr    = 1'b0;
        bus_size  = 3'b010;
        bus_wstrb = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (w_sel_d) begin
            bus_wr    = (d_en == 2'b10);
            bus_size  = d_size;
            bus_wstrb = (d_en == 2'b10) ? w_byte_select : '0;
            bus_addr  = d_addr;
            bus_wdata = d_wdata;
        end else if (w_sel_i) begin
            bus_addr  = i_addr;
        end
    end

    assign bus_req = !rst && (w_sel_d || w_sel_i);
    assign d_stall = !rst && w_d_stall;
    assign i_stall = !rst && w_i_stall;
    assign d_rdata = rst ? '0 : (w_d_fin ? bus_rdata : d_buf_q);
    assign i_rdata = rst ? '0 : (w_i_fin ? bus_rdata : i_buf_q);

    always_comb begin
        state_d  = state_q;
        d_done_d = d_done_q;
        i_done_d = i_done_q;
        d_buf_d  = d_buf_q;
        i_buf_d  = i_buf_q;

        case (state_q)
            S_IDLE: begin
                if (w_d_pend)      state_d = bus_addr_ok ? S_D_WAIT : S_D_REQ;
                else if (w_i_pend) state_d = bus_addr_ok ? S_I_WAIT : S_I_REQ;
            end
            S_D_REQ:  if (bus_addr_ok) state_d = S_D_WAIT;
            S_I_REQ:  if (bus_addr_ok) state_d = S_I_WAIT;
            S_D_WAIT: if (bus_data_ok) state_d = S_IDLE;
            S_I_WAIT: if (bus_data_ok) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (w_d_fin) d_buf_d = bus_rdata;
        if (w_i_fin) i_buf_d = bus_rdata;

        // Done flags hold completed results until the whole pipeline moves.
        if (w_advance) begin
            d_done_d = 1'b0;
            i_done_d = 1'b0;
        end else begin
            if (w_d_fin) d_done_d = 1'b1;
            if (w_i_fin) i_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            d_done_q <= 1'b0;
            i_done_q <= 1'b0;
            d_buf_q  <= '0;
            i_buf_q  <= '0;
        end else begin
            state_q  <= state_d;
            d_done_q <= d_done_d;
            i_done_q <= i_done_d;
            d_buf_q  <= d_buf_d;
            i_buf_q  <= i_buf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Directed self-checking bench for mem_port_arbiter.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic [1:0]  d_en;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_size;
    logic [3:0]  w_byte_select;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [2:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_issue = 0;
    int n_req_cyc = 0;
    int base_issue;
    int base_req;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_en(d_en), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .w_byte_select(w_byte_select), .d_rdata(d_rdata), .d_stall(d_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus_req) n_req_cyc++;
        if (!rst && bus_req && bus_addr_ok) n_issue++;
    end

    // Inputs change 1 time unit after a rising edge; checks happen at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_in(input logic aok, input logic dok, input logic [31:0] rd);
        bus_addr_ok = aok;
        bus_data_ok = dok;
        bus_rdata   = rd;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_en = 1'b1; i_addr = 32'hBFC0_0000;
        d_en = 2'b01; d_addr = 32'h0; d_wdata = 32'h0; d_size = 3'b010;
        w_byte_select = 4'b0000;
        bus_in(1'b0, 1'b0, 32'h0);
        #4;
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_d_stall", d_stall, 1'b0);
        check("rst_i_stall", i_stall, 1'b0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        tick();
        rst = 1'b0; i_en = 1'b0; d_en = 2'b00;
        tick();

        // Single load
        d_en = 2'b01; d_addr = 32'h0000_1000; bus_in(1'b1, 1'b0, 32'h0);
        #4;
        check("ld_c0_req", bus_req, 1'b1);
        check("ld_c0_addr", bus_addr, 32'h0000_1000);
        check("ld_c0_wr", bus_wr, 1'b0);
        check("ld_c0_wstrb", bus_wstrb, 4'b0000);
        check("ld_c0_stall", d_stall, 1'b1);
        tick();
        bus_in(1'b0, 1'b1, 32'hDEAD_BEEF);
        #4;
        check("ld_c1_req", bus_req, 1'b0);
        check("ld_c1_stall", d_stall, 1'b0);
        check("ld_c1_rdata", d_rdata, 32'hDEAD_BEEF);
        tick();
        d_en = 2'b00; bus_in(1'b0, 1'b0, 32'h0);
        #4;
        check("ld_c2_buf", d_rdata, 32'hDEAD_BEEF);
        check("ld_c2_req", bus_req, 1'b0);
        tick();

        // Store byte
        d_en = 2'b10; d_addr = 32'h0000_1004; d_size = 3'b000;
        w_byte_select = 4'b0100; d_wdata = 32'h5A5A_5A5A; bus_in(1'b1, 1'b0, 32'h0);
        #4;
        check("st_req", bus_req, 1'b1);
        check("st_wr", bus_wr, 1'b1);
        check("st_wstrb", bus_wstrb, 4'b0100);
        check("st_size", bus_size, 3'b000);
        check("st_wdata", bus_wdata, 32'h5A5A_5A5A);
        check("st_c0_stall", d_stall, 1'b1);
        tick();
        bus_in(1'b0, 1'b1, 32'h0);
        #4;
        check("st_c1_stall", d_stall, 1'b0);
        tick();
        d_en = 2'b00; d_size = 3'b010; w_byte_select = 4'b0000; bus_in(1'b0, 1'b0, 32'h0);
        tick();

        // Simultaneous fetch and load; also no reissue of the held load
        base_issue = n_issue; base_req = n_req_cyc;
        d_en = 2'b01; d_addr = 32'h0000_2000; i_en = 1'b1; i_addr = 32'hBFC0_0000;
        bus_in(1'b1, 1'b0, 32'h0);
        #4;
        check("sim_c0_addr", bus_addr, 32'h0000_2000);
        check("sim_c0_dstall", d_stall, 1'b1);
        check("sim_c0_istall", i_stall, 1'b1);
        tick();
        bus_in(1'b0, 1'b1, 32'h1111_1111);
        #4;
        check("sim_c1_req", bus_req, 1'b0);
        check("sim_c1_dstall", d_stall, 1'b0);
        check("sim_c1_istall", i_stall, 1'b1);
        check("sim_c1_drdata", d_rdata, 32'h1111_1111);
        tick();
        bus_in(1'b1, 1'b0, 32'h0);
        #4;
        check("sim_c2_req", bus_req, 1'b1);
        check("sim_c2_addr", bus_addr, 32'hBFC0_0000);
        check("sim_c2_size", bus_size, 3'b010);
        check("sim_c2_wr", bus_wr, 1'b0);
        check("sim_c2_dstall", d_stall, 1'b0);
        check("sim_c2_istall", i_stall, 1'b1);
        check("sim_c2_dbuf", d_rdata, 32'h1111_1111);
        tick();
        bus_in(1'b0, 1'b1, 32'h2222_2222);
        #4;
        check("sim_c3_istall", i_stall, 1'b0);
        check("sim_c3_irdata", i_rdata, 32'h2222_2222);
        check("sim_c3_dbuf", d_rdata, 32'h1111_1111);
        tick();
        d_en = 2'b00; i_en = 1'b0; bus_in(1'b0, 1'b0, 32'h0);
        #4;
        check("sim_issues", n_issue - base_issue, 2);
        check("sim_req_cycles", n_req_cyc - base_req, 2);
        tick();

        // Fetch grant locked while addr_ok is held low
        i_en = 1'b1; i_addr = 32'hBFC0_0000; bus_in(1'b0, 1'b0, 32'h0);
        #4;
        check("lk_c0_addr", bus_addr, 32'hBFC0_0000);
        tick();
        d_en = 2'b01; d_addr = 32'h0000_3000;
        #4;
        check("lk_c1_req", bus_req, 1'b1);
        check("lk_c1_addr", bus_addr, 32'hBFC0_0000);
        check("lk_c1_dstall", d_stall, 1'b1);
        tick();
        #4;
        check("lk_c2_addr", bus_addr, 32'hBFC0_0000);
        tick();
        bus_in(1'b1, 1'b0, 32'h0);
        #4;
        check("lk_c3_addr", bus_addr, 32'hBFC0_0000);
        tick();
        bus_in(1'b0, 1'b1, 32'h3333_3333);
        #4;
        check("lk_c4_req", bus_req, 1'b0);
        check("lk_c4_istall", i_stall, 1'b0);
        check("lk_c4_irdata", i_rdata, 32'h3333_3333);
        check("lk_c4_dstall", d_stall, 1'b1);
        tick();
        bus_in(1'b1, 1'b0, 32'h0);
        #4;
        check("lk_c5_req", bus_req, 1'b1);
        check("lk_c5_addr", bus_addr, 32'h0000_3000);
        check("lk_c5_istall", i_stall, 1'b0);
        tick();
        bus_in(1'b0, 1'b1, 32'h4444_4444);
        #4;
        check("lk_c6_dstall", d_stall, 1'b0);
        check("lk_c6_drdata", d_rdata, 32'h4444_4444);
        tick();
        d_en = 2'b00; i_en = 1'b0; bus_in(1'b0, 1'b0, 32'h0);
        tick();

        // Async reset while waiting for load data
        d_en = 2'b01; d_addr = 32'h0000_5000; bus_in(1'b1, 1'b0, 32'h0);
        tick();
        bus_in(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req", bus_req, 1'b0);
        check("ar_dstall", d_stall, 1'b0);
        check("ar_istall", i_stall, 1'b0);
        tick();
        rst = 1'b0; d_en = 2'b00; bus_in(1'b0, 1'b1, 32'h9999_9999);
        #4;
        check("ar_stray_rdata", d_rdata, 32'h0);
        check("ar_stray_req", bus_req, 1'b0);
        tick();
        d_en = 2'b01; bus_in(1'b0, 1'b0, 32'h0);
        #4;
        check("ar_idle_req", bus_req, 1'b1);
        check("ar_idle_dstall", d_stall, 1'b1);
        tick();
        bus_in(1'b1, 1'b0, 32'h0);
        tick();
        bus_in(1'b0, 1'b1, 32'h5555_5555);
        #4;
        check("ar_post_rdata", d_rdata, 32'h5555_5555);
        check("ar_post_dstall", d_stall, 1'b0);
        tick();
        d_en = 2'b00; bus_in(1'b0, 1'b0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory bus (req / addr_ok / data_ok) between the instruction-fetch port and the MEM-stage data port.
- Data requests have priority over fetch. Each request is held on the bus until it is accepted, and the block tracks the outstanding transaction.
- Results are buffered so each access is issued exactly once per pipeline advance. The block generates the per-port stall signals that freeze the pipeline.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte strobe width = DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_en  in  1  fetch request valid
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched instruction
i_stall  out  1  fetch port not finished
d_en  in  2  00 none, 01 load, 10 store, 11 treated as none
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data, already lane-replicated
d_size  in  3  000 byte, 001 half, 010 word
w_byte_select  in  DATA_W/8  store byte strobes
d_rdata  out  DATA_W  raw load word (MEM stage does the extension)
d_stall  out  1  data port not finished
bus_req  out  1  bus request
bus_wr  out  1  1 = write
bus_size  out  3  copy of the granted size (word 010 for fetch)
bus_wstrb  out  DATA_W/8  strobes; 0 for reads
bus_addr  out  ADDR_W  request address
bus_wdata  out  DATA_W  write data
bus_addr_ok  in  1  request accepted this cycle
bus_data_ok  in  1  response/ack this cycle (earliest: 1 cycle after addr_ok)
bus_rdata  in  DATA_W  read data, valid with data_ok

Behaviour:
- Reset: rst is asynchronous and active-high. It forces state IDLE, d_done=i_done=0, and d_buf=i_buf=0. While rst is high, bus_req, d_stall, i_stall, d_rdata and i_rdata are all 0.
- States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT.
- Pending: d_pend = (d_en==01 or 10) and !d_done; i_pend = i_en and !i_done.
- IDLE:
  - If d_pend: drive the bus with data fields and set bus_req=1. Go to D_WAIT if addr_ok, else D_REQ.
  - Else if i_pend: drive the fetch fields and set bus_req=1. Go to I_WAIT if addr_ok, else I_REQ.
  - Else bus_req=0.
- D_REQ / I_REQ: the granted request is locked. bus_req=1 with that port's fields, even if a higher-priority request appears. On addr_ok, go to the matching *_WAIT state.
- D_WAIT / I_WAIT: bus_req=0. On data_ok: capture bus_rdata into the port buffer (stores capture as well; the value is don't-care), set that port's done flag, and go to IDLE.
- bus_data_ok in IDLE or *_REQ is ignored. At most one transaction is outstanding.
- Completion forwarding: in the data_ok cycle the port's rdata = bus_rdata, combinationally. In later cycles it equals the buffer.
- Stalls:
  - d_stall = d_en valid and !(d_done or (state==D_WAIT and data_ok)).
  - i_stall = i_en and !(i_done or (state==I_WAIT and data_ok)).
- Advance = !d_stall and !i_stall. On advance, both done flags clear next cycle, so a held request is never reissued while the other port still stalls.
- Bus fields for fetch: bus_wr=0, bus_size=010, bus_wstrb=0, bus_wdata=0.
- Bus fields for data: bus_wr=(d_en==10), bus_size=d_size, bus_wstrb=w_byte_select for stores and 0 for loads, bus_wdata=d_wdata.
- Simultaneous requests from IDLE: data first, then fetch. Minimum cost is 2 cycles each, with zero-wait addr_ok.
- A requester withdrawing its request while in *_REQ or *_WAIT: the transaction completes on the bus anyway, and the done flag is cleared on the next advance.
- Reset mid-transaction: the bus response is lost by design. The bus side must be reset together with this block.

Test Plan:
- Single load: d_en=01, addr 0x1000, addr_ok in cycle 0, data_ok plus rdata 0xDEADBEEF in cycle 1. Expected: d_stall=1,0; d_rdata=0xDEADBEEF in cycle 1; bus_req high in cycle 0 only.
- Store byte: d_en=10, d_size=000, strobes 0100, wdata 0x5A5A5A5A. Expected: bus_wr=1, bus_wstrb=0100, bus_size=000; stall drops on data_ok.
- Simultaneous fetch 0xBFC00000 and load 0x2000, both zero-wait. Expected: data is issued first; fetch is issued in cycle 2; d_stall low from cycle 1; i_stall low in cycle 3; exactly 2 bus_req pulses.
- Lock: fetch is issued with addr_ok held low for 3 cycles, and a load arrives in cycle 1. Expected: bus_addr stays 0xBFC00000 until addr_ok; the load is issued after fetch data_ok.
- No reissue: the load completes while the fetch is still stalled and d_en is held. Expected: exactly one data bus_req; d_rdata stays at the buffered value until advance.
- Async reset asserted in D_WAIT. Expected: immediately bus_req=0, stalls=0, state IDLE; a later stray data_ok is ignored.
